// File: rtl/udm_uart_rx.sv
// udm_uart_rx
// UART receive front end for the UDM debug path. The rx_i pin is synchronised,
// 8N1 frames are detected and validated at a run-time bit divider, and each
// received byte is buffered in a small FIFO. The FIFO is drained through a
// valid/ready handshake.
//
// Ports:
//   clk_i        system clock
//   srst_i       synchronous reset, active-high
//   divider_i    clock cycles per UART bit (values below 4 behave as 4)
//   rx_i         asynchronous serial input, idle high
//   rdata_o      byte at the FIFO head (0 while the FIFO is empty)
//   rvalid_o     FIFO holds at least one byte
//   rready_i     consumer takes rdata_o when rvalid_o is high
//   busy_o       a frame is in progress (receiver not idle)
//   frame_err_o  one-cycle pulse: the stop bit was sampled low
//   overflow_o   one-cycle pulse: a good byte was dropped because the FIFO was full
module udm_uart_rx #(
    parameter int DIV_WIDTH   = 16,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk_i,
    input  logic                 srst_i,
    input  logic [DIV_WIDTH-1:0] divider_i,
    input  logic                 rx_i,
    output logic [7:0]           rdata_o,
    output logic                 rvalid_o,
    input  logic                 rready_i,
    output logic                 busy_o,
    output logic                 frame_err_o,
    output logic                 overflow_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;

    state_e                 state_q;
    logic [DIV_WIDTH-1:0]   cnt_q;
    logic [DIV_WIDTH-1:0]   div_l_q;
    logic [2:0]             bit_idx_q;
    logic [7:0]             shift_q;
    logic                   frame_err_q;

    logic [DIV_WIDTH-1:0]   div_eff;
    logic [DIV_WIDTH-1:0]   half_m1;
    logic [DIV_WIDTH-1:0]   full_m1;
    logic                   stop_sample;
    logic                   push;

    logic [7:0]             mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]       wptr_q, wptr_d;
    logic [PTR_W-1:0]       rptr_q, rptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   overflow_q;
    logic                   full;
    logic                   pop;
    logic                   do_push;

    // Synchroniser: reset to the idle level so a reset never fakes a start bit.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];

    // Divider floor of 4 keeps the half-bit count at least 2 cycles.
    assign div_eff     = (divider_i < DIV_WIDTH'(4)) ? DIV_WIDTH'(4) : divider_i;
    assign half_m1     = (div_l_q >> 1) - DIV_WIDTH'(1);
    assign full_m1     = div_l_q - DIV_WIDTH'(1);
    assign stop_sample = (state_q == ST_STOP) && (cnt_q == full_m1);
    assign push        = stop_sample && rx_s;

    // Frame FSM. The start bit is checked at its middle, then every later bit
    // is a full bit period on, so all samples land mid-bit.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            div_l_q     <= DIV_WIDTH'(4);
            bit_idx_q   <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state_q <= ST_START;
                        cnt_q   <= '0;
                        div_l_q <= div_eff;
                    end
                end
                ST_START: begin
                    if (cnt_q == half_m1) begin
                        cnt_q     <= '0;
                        bit_idx_q <= '0;
                        state_q   <= rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt_q <= cnt_q + DIV_WIDTH'(1);
                    end
                end
                ST_DATA: begin
                    if (cnt_q == full_m1) begin
                        cnt_q     <= '0;
                        shift_q   <= {rx_s, shift_q[7:1]};
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= ST_STOP;
                        end
                    end else begin
                        cnt_q <= cnt_q + DIV_WIDTH'(1);
                    end
                end
                ST_STOP: begin
                    if (cnt_q == full_m1) begin
                        cnt_q <= '0;
                        if (rx_s) begin
                            state_q <= ST_IDLE;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= ST_BREAK;
                        end
                    end else begin
                        cnt_q <= cnt_q + DIV_WIDTH'(1);
                    end
                end
                ST_BREAK: begin
                    // A held-low line stays here so it reports only one error.
                    if (rx_s) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // A push into a full FIFO still succeeds when the head is popped in the same cycle.
    assign full     = (count_q == CNT_W'(FIFO_DEPTH));
    assign rvalid_o = (count_q != '0);
    assign pop      = rvalid_o && rready_i;
    assign do_push  = push && (!full || pop);

    // Next-state pointer and occupancy arithmetic.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) begin
            wptr_d = wptr_q + PTR_W'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + PTR_W'(1);
        end
        case ({do_push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO bookkeeping and the overflow pulse.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            overflow_q <= push && full && !pop;
        end
    end

    // Storage needs no reset; the head is masked while the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wptr_q] <= shift_q;
        end
    end

    assign rdata_o     = rvalid_o ? mem_q[rptr_q] : 8'h00;
    assign busy_o      = (state_q != ST_IDLE);
    assign frame_err_o = frame_err_q;
    assign overflow_o  = overflow_q;

endmodule
